midi_stream_parser: RTL and testbench



---
 rtl/midi_pkg.sv | 44 ++++
 rtl/midi_msg_fifo.sv | 67 ++++++
 rtl/midi_stream_parser.sv | 168 ++++++++++++++++
 tb/tb_midi_stream_parser.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and byte codes for the MIDI channel-voice parser and its output FIFO.
package midi_pkg;

   typedef enum logic [2:0] {
      MSG_NOTE_OFF = 3'd0,
      MSG_NOTE_ON  = 3'd1,
      MSG_POLY_AT  = 3'd2,
      MSG_CC       = 3'd3,
      MSG_PROGRAM  = 3'd4,
      MSG_CHAN_AT  = 3'd5,
      MSG_BEND     = 3'd6
   } msg_type_e;

   typedef struct packed {
      msg_type_e  mtype;
      logic [3:0] channel;
      logic [6:0] data1;
      logic [6:0] data2;
   } midi_msg_t;

   localparam logic [7:0] STATUS_SYSEX = 8'hF0;
   localparam logic [7:0] SC_MTC_QF    = 8'hF1;
   localparam logic [7:0] SC_SONG_POS  = 8'hF2;
   localparam logic [7:0] SC_SONG_SEL  = 8'hF3;
   localparam logic [7:0] SC_UNDEF_F4  = 8'hF4;
   localparam logic [7:0] SC_UNDEF_F5  = 8'hF5;
   localparam logic [7:0] SC_TUNE_REQ  = 8'hF6;
   localparam logic [7:0] EOX          = 8'hF7;
   localparam logic [7:0] RT_MIN       = 8'hF8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_D1 = 3'd1,
      WAIT_D2 = 3'd2,
      SYSEX   = 3'd3,
      SKIP    = 3'd4
   } parser_state_e;

   // Program change and channel aftertouch carry a single data byte.
   function automatic logic one_data_byte(input msg_type_e t);
      return (t == MSG_PROGRAM) || (t == MSG_CHAN_AT);
   endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// First-word fall-through FIFO of MIDI messages; head, valid and count come straight from registers.
module midi_msg_fifo
   import midi_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push,
   input  midi_msg_t                  push_data,
   input  logic                       pop,
   output midi_msg_t                  head,
   output logic                       head_valid,
   output logic                       empty_c,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   midi_msg_t        mem [DEPTH];
   midi_msg_t        head_q;
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic             valid_q, ovf_q;
   logic             full, do_pop, do_push;

   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      do_pop   = pop && valid_q;
      do_push  = push && (!full || do_pop);
      rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;
      cnt_n    = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // A push into an otherwise-empty FIFO bypasses storage so the head appears next cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_n;
         cnt_q   <= cnt_n;
         valid_q <= (cnt_n != '0);
         if (cnt_n != '0)
            head_q <= (do_push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
         if (push && !do_push) ovf_q <= 1'b1;
      end
   end

   assign head       = head_q;
   assign head_valid = valid_q;
   assign empty_c    = !valid_q;
   assign count      = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: rtl/midi_stream_parser.sv
// MIDI 1.0 channel-voice parser: running status, real-time passthrough, SysEx/system-common skip, timeout.
module midi_stream_parser
   import midi_pkg::*;
#(
   parameter int unsigned CLK_FREQ            = 200_000_000,
   parameter int unsigned BAUD_RATE           = 31_250,
   parameter int unsigned TIMEOUT_BYTE_TIMES  = 20,
   parameter int unsigned FIFO_DEPTH          = 8,
   parameter bit          NOTE_ON_ZERO_IS_OFF = 1'b1
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          byte_valid_in,
   input  logic [7:0]                    byte_in,
   input  logic [15:0]                   chan_mask_in,
   output logic                          msg_valid_out,
   input  logic                          msg_ready_in,
   output logic [2:0]                    msg_type_out,
   output logic [3:0]                    msg_channel_out,
   output logic [6:0]                    msg_data1_out,
   output logic [6:0]                    msg_data2_out,
   output logic                          rt_valid_out,
   output logic [7:0]                    rt_code_out,
   output logic                          err_orphan_out,
   output logic                          err_timeout_out,
   output logic                          overflow_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

   localparam int unsigned TIMEOUT_CYCLES =
      32'(64'(TIMEOUT_BYTE_TIMES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUD_RATE));
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   parser_state_e    state, state_n;
   msg_type_e        rs_type, rs_type_n;
   logic [3:0]       rs_chan, rs_chan_n;
   logic [6:0]       d1, d1_n, d2_c;
   logic [1:0]       skip, skip_n;
   logic [TO_W-1:0]  to_cnt, to_cnt_n;
   logic             rt_valid_q, rt_valid_n, orphan_q, orphan_n, timeout_q, timeout_n;
   logic [7:0]       rt_code_q, rt_code_n;
   logic             is_rt, non_rt, done_c, push_c, pop_c, empty_c;
   midi_msg_t        msg_c, head;

   assign is_rt  = byte_valid_in && (byte_in >= RT_MIN);
   assign non_rt = byte_valid_in && !is_rt;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         rs_type    <= MSG_NOTE_OFF;
         rs_chan    <= '0;
         d1         <= '0;
         skip       <= '0;
         to_cnt     <= '0;
         rt_valid_q <= 1'b0;
         rt_code_q  <= '0;
         orphan_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_n;
         rs_type    <= rs_type_n;
         rs_chan    <= rs_chan_n;
         d1         <= d1_n;
         skip       <= skip_n;
         to_cnt     <= to_cnt_n;
         rt_valid_q <= rt_valid_n;
         rt_code_q  <= rt_code_n;
         orphan_q   <= orphan_n;
         timeout_q  <= timeout_n;
      end
   end

   // Real-time bytes touch only the rt outputs; every other byte resets the gap counter.
   always_comb begin
      state_n    = state;
      rs_type_n  = rs_type;
      rs_chan_n  = rs_chan;
      d1_n       = d1;
      d2_c       = '0;
      skip_n     = skip;
      to_cnt_n   = to_cnt;
      rt_valid_n = 1'b0;
      rt_code_n  = rt_code_q;
      orphan_n   = 1'b0;
      timeout_n  = 1'b0;
      done_c     = 1'b0;
      if (is_rt) begin
         rt_valid_n = 1'b1;
         rt_code_n  = byte_in;
      end
      if (non_rt) begin
         to_cnt_n = '0;
         if (!byte_in[7]) begin
            case (state)
               IDLE:    orphan_n = 1'b1;
               WAIT_D1: begin
                  d1_n = byte_in[6:0];
                  if (one_data_byte(rs_type)) done_c = 1'b1;
                  else                        state_n = WAIT_D2;
               end
               WAIT_D2: begin
                  d2_c    = byte_in[6:0];
                  done_c  = 1'b1;
                  state_n = WAIT_D1;
               end
               SKIP: begin
                  skip_n = skip - 2'd1;
                  if (skip == 2'd1) state_n = IDLE;
               end
               default: ;
            endcase
         end else if (byte_in < STATUS_SYSEX) begin
            rs_type_n = msg_type_e'(byte_in[6:4]);
            rs_chan_n = byte_in[3:0];
            state_n   = WAIT_D1;
         end else begin
            case (byte_in)
               STATUS_SYSEX:           state_n = SYSEX;
               SC_MTC_QF, SC_SONG_SEL: begin state_n = SKIP; skip_n = 2'd1; end
               SC_SONG_POS:            begin state_n = SKIP; skip_n = 2'd2; end
               default:                state_n = IDLE;
            endcase
         end
      end else if (state == WAIT_D2) begin
         if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            timeout_n = 1'b1;
            state_n   = WAIT_D1;
            to_cnt_n  = '0;
         end else if (to_cnt != '1) begin
            to_cnt_n = to_cnt + TO_W'(1);
         end
      end
   end

   always_comb begin
      msg_c.mtype   = (NOTE_ON_ZERO_IS_OFF && rs_type == MSG_NOTE_ON && d2_c == '0)
                      ? MSG_NOTE_OFF : rs_type;
      msg_c.channel = rs_chan;
      msg_c.data1   = d1_n;
      msg_c.data2   = d2_c;
      push_c        = done_c && chan_mask_in[rs_chan];
      pop_c         = msg_ready_in && !empty_c;
   end

   midi_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .push       (push_c),
      .push_data  (msg_c),
      .pop        (pop_c),
      .head       (head),
      .head_valid (msg_valid_out),
      .empty_c    (empty_c),
      .count      (fifo_count_out),
      .overflow   (overflow_out)
   );

   assign msg_type_out    = head.mtype;
   assign msg_channel_out = head.channel;
   assign msg_data1_out   = head.data1;
   assign msg_data2_out   = head.data2;
   assign rt_valid_out    = rt_valid_q;
   assign rt_code_out     = rt_code_q;
   assign err_orphan_out  = orphan_q;
   assign err_timeout_out = timeout_q;

endmodule

// File: tb/tb_midi_stream_parser.sv
// Directed bench for midi_stream_parser with a byte-level reference model and per-cycle scoreboard.
module tb_midi_stream_parser;

   localparam int unsigned DEPTH = 8;
   localparam int          TO    = 200;   // 2 byte times * 10 bits * (312500/31250)

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        byte_valid_in = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic [15:0] chan_mask_in = 16'hFFFF;
   logic        msg_ready_in = 1'b1;

   logic        msg_valid_out, rt_valid_out, err_orphan_out, err_timeout_out, overflow_out;
   logic [2:0]  msg_type_out;
   logic [3:0]  msg_channel_out;
   logic [6:0]  msg_data1_out, msg_data2_out;
   logic [7:0]  rt_code_out;
   logic [3:0]  fifo_count_out;

   logic        b_msg_valid, b_rt_valid, b_orphan, b_timeout, b_overflow;
   logic [2:0]  b_type;
   logic [3:0]  b_channel;
   logic [6:0]  b_d1, b_d2;
   logic [7:0]  b_rt_code;
   logic [3:0]  b_count;

   always #5 clk_in = ~clk_in;

   midi_stream_parser #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .TIMEOUT_BYTE_TIMES(2),
                        .FIFO_DEPTH(DEPTH), .NOTE_ON_ZERO_IS_OFF(1'b1)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .byte_valid_in(byte_valid_in), .byte_in(byte_in),
      .chan_mask_in(chan_mask_in), .msg_valid_out(msg_valid_out), .msg_ready_in(msg_ready_in),
      .msg_type_out(msg_type_out), .msg_channel_out(msg_channel_out),
      .msg_data1_out(msg_data1_out), .msg_data2_out(msg_data2_out),
      .rt_valid_out(rt_valid_out), .rt_code_out(rt_code_out), .err_orphan_out(err_orphan_out),
      .err_timeout_out(err_timeout_out), .overflow_out(overflow_out),
      .fifo_count_out(fifo_count_out));

   midi_stream_parser #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .TIMEOUT_BYTE_TIMES(2),
                        .FIFO_DEPTH(DEPTH), .NOTE_ON_ZERO_IS_OFF(1'b0)) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .byte_valid_in(byte_valid_in), .byte_in(byte_in),
      .chan_mask_in(chan_mask_in), .msg_valid_out(b_msg_valid), .msg_ready_in(msg_ready_in),
      .msg_type_out(b_type), .msg_channel_out(b_channel),
      .msg_data1_out(b_d1), .msg_data2_out(b_d2),
      .rt_valid_out(b_rt_valid), .rt_code_out(b_rt_code), .err_orphan_out(b_orphan),
      .err_timeout_out(b_timeout), .overflow_out(b_overflow),
      .fifo_count_out(b_count));

   wire [20:0] head_a = {msg_type_out, msg_channel_out, msg_data1_out, msg_data2_out};
   wire [20:0] head_b = {b_type, b_channel, b_d1, b_d2};

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pack(input int t, input int c, input int a, input int b);
      return (t << 18) | (c << 14) | (a << 7) | b;
   endfunction

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_MSG, M_SYSEX, M_SKIP} mmode_e;
   mmode_e mode = M_IDLE;
   int  rs = 0, skip_left = 0, idle_cyc = 0;
   int  pend[$];
   int  q1[$], q0[$];
   bit  ovf1 = 0, ovf0 = 0, e_rtv = 0, e_orph = 0, e_tmo = 0;
   int  e_rtc = 0;
   bit  done, non_rt_byte;
   int  t, c, d1v, d2v, need;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mode = M_IDLE; rs = 0; skip_left = 0; idle_cyc = 0; pend.delete();
         q1.delete(); q0.delete(); ovf1 = 0; ovf0 = 0;
         e_rtv = 0; e_orph = 0; e_tmo = 0; e_rtc = 0;
      end else begin
         e_rtv = 0; e_orph = 0; e_tmo = 0; done = 0; non_rt_byte = 0;
         if (byte_valid_in && byte_in >= 8'hF8) begin
            e_rtv = 1; e_rtc = int'(byte_in);
         end else if (byte_valid_in) begin
            non_rt_byte = 1; idle_cyc = 0;
            if (byte_in >= 8'h80 && byte_in < 8'hF0) begin
               rs = int'(byte_in); pend.delete(); mode = M_MSG;
            end else if (byte_in == 8'hF0) mode = M_SYSEX;
            else if (byte_in == 8'hF1 || byte_in == 8'hF3) begin mode = M_SKIP; skip_left = 1; end
            else if (byte_in == 8'hF2) begin mode = M_SKIP; skip_left = 2; end
            else if (byte_in >= 8'hF4) mode = M_IDLE;
            else begin
               case (mode)
                  M_IDLE: e_orph = 1;
                  M_SKIP: begin skip_left--; if (skip_left == 0) mode = M_IDLE; end
                  M_MSG: begin
                     pend.push_back(int'(byte_in));
                     t = (rs >> 4) & 7;
                     need = (t == 4 || t == 5) ? 1 : 2;
                     if (pend.size() == need) begin
                        done = 1; c = rs & 15; d1v = pend[0];
                        d2v = (need == 2) ? pend[1] : 0;
                        pend.delete();
                     end
                  end
                  default: ;
               endcase
            end
         end
         if (!non_rt_byte && mode == M_MSG && pend.size() > 0) begin
            if (idle_cyc == TO) begin e_tmo = 1; pend.delete(); idle_cyc = 0; end
            else idle_cyc++;
         end
         if (msg_ready_in && q1.size() > 0) void'(q1.pop_front());
         if (msg_ready_in && q0.size() > 0) void'(q0.pop_front());
         if (done && chan_mask_in[c]) begin
            if (q1.size() < DEPTH) q1.push_back(pack((t == 1 && d2v == 0) ? 0 : t, c, d1v, d2v));
            else ovf1 = 1;
            if (q0.size() < DEPTH) q0.push_back(pack(t, c, d1v, d2v));
            else ovf0 = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_in) begin
      if (rst_in) begin
         chk("rt_valid", rt_valid_out, e_rtv);
         chk("rt_code", rt_code_out, e_rtc);
         chk("err_orphan", err_orphan_out, e_orph);
         chk("err_timeout", err_timeout_out, e_tmo);
         chk("overflow", overflow_out, ovf1);
         chk("fifo_count", fifo_count_out, q1.size());
         chk("msg_valid", msg_valid_out, q1.size() > 0);
         if (q1.size() > 0) chk("head", head_a, q1[0]);
         chk("b_overflow", b_overflow, ovf0);
         chk("b_fifo_count", b_count, q0.size());
         chk("b_msg_valid", b_msg_valid, q0.size() > 0);
         if (q0.size() > 0) chk("b_head", head_b, q0[0]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send(input logic [7:0] b);
      @(posedge clk_in); #1;
      byte_valid_in = 1'b1; byte_in = b;
      @(posedge clk_in); #1;
      byte_valid_in = 1'b0;
   endtask

   int n_tmo;

   initial begin
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b1;
      @(negedge clk_in);
      chk("rst_msg_valid", msg_valid_out, 0);
      chk("rst_count", fifo_count_out, 0);
      chk("rst_overflow", overflow_out, 0);
      chk("rst_rt_code", rt_code_out, 0);

      // single message and push-to-valid latency
      send(8'h93); send(8'h3C);
      @(posedge clk_in); #1 byte_valid_in = 1'b1; byte_in = 8'h64;
      @(negedge clk_in); chk("lat_before", msg_valid_out, 0);
      @(posedge clk_in); #1 byte_valid_in = 1'b0;
      @(negedge clk_in); chk("lat_after", msg_valid_out, 1);
      chk("head_933c64", head_a, pack(1, 3, 'h3C, 'h64));

      // running status with note-on velocity 0
      send(8'h90); send(8'h40); send(8'h7F); send(8'h41); send(8'h00);
      @(negedge clk_in);
      chk("rs_zero_off", head_a, pack(0, 0, 'h41, 0));
      chk("rs_zero_on", head_b, pack(1, 0, 'h41, 0));

      // interleaved real-time
      send(8'h90); send(8'hF8);
      @(negedge clk_in); chk("rt_f8_valid", rt_valid_out, 1); chk("rt_f8_code", rt_code_out, 8'hF8);
      send(8'h40); send(8'hFE); send(8'h7F);
      @(negedge clk_in); chk("rt_intact", head_a, pack(1, 0, 'h40, 'h7F));
      chk("rt_code_held", rt_code_out, 8'hFE);

      // program change, SysEx, orphan
      send(8'hC5); send(8'h0A);
      @(negedge clk_in); chk("prog_0a", head_a, pack(4, 5, 'h0A, 0));
      send(8'h0B);
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h20);
      @(negedge clk_in); chk("orphan_20", err_orphan_out, 1);

      // other channel-voice types and system-common skipping
      send(8'hA1); send(8'h10); send(8'h20); send(8'hD2); send(8'h33);
      send(8'hE3); send(8'h00); send(8'h40);
      @(negedge clk_in); chk("bend", head_a, pack(6, 3, 0, 'h40));
      send(8'hF2); send(8'h01); send(8'h02); send(8'hF3); send(8'h05); send(8'h10);
      @(negedge clk_in); chk("orphan_after_skip", err_orphan_out, 1);

      // channel mask
      chan_mask_in = 16'hFFFE;
      send(8'h80); send(8'h10); send(8'h20);
      @(negedge clk_in); chk("mask_drop", msg_valid_out, 0);
      send(8'h81); send(8'h10); send(8'h20);
      @(negedge clk_in); chk("mask_pass", head_a, pack(0, 1, 'h10, 'h20));
      chan_mask_in = 16'hFFFF;

      // fill, overflow, full-with-pop
      msg_ready_in = 1'b0;
      send(8'h90);
      for (int i = 1; i <= DEPTH + 1; i++) begin send(8'(i)); send(8'h01); end
      @(negedge clk_in);
      chk("full_count", fifo_count_out, DEPTH);
      chk("overflow_set", overflow_out, 1);
      send(8'h20);
      @(posedge clk_in); #1 byte_valid_in = 1'b1; byte_in = 8'h01; msg_ready_in = 1'b1;
      @(posedge clk_in); #1 byte_valid_in = 1'b0;
      @(negedge clk_in); chk("full_pop_push", fifo_count_out, DEPTH);
      repeat (DEPTH + 2) @(posedge clk_in);

      // timeout then running status resumes
      send(8'hB0); send(8'h07);
      n_tmo = 0;
      for (int i = 0; i < TO + 60; i++) begin
         @(negedge clk_in);
         if (err_timeout_out) n_tmo++;
      end
      chk("timeout_pulses", n_tmo, 1);
      send(8'h07); send(8'h64);
      @(negedge clk_in); chk("after_timeout", head_a, pack(3, 0, 'h07, 'h64));

      // asynchronous reset mid-message
      msg_ready_in = 1'b0;
      send(8'h93); send(8'h3C); send(8'h64); send(8'hFA); send(8'h90); send(8'h40);
      @(negedge clk_in); #2 rst_in = 1'b0; #1;
      chk("arst_msg_valid", msg_valid_out, 0);
      chk("arst_head", head_a, 0);
      chk("arst_rt", {rt_valid_out, rt_code_out}, 0);
      chk("arst_errs", {err_orphan_out, err_timeout_out}, 0);
      chk("arst_overflow", overflow_out, 0);
      chk("arst_count", fifo_count_out, 0);
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1; msg_ready_in = 1'b1;
      send(8'h50);
      @(negedge clk_in); chk("post_rst_orphan", err_orphan_out, 1);
      repeat (3) @(posedge clk_in);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
